// File: rtl/scan_unlock_auth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | scan_unlock_auth                                                         |
// | Constant-time scan-key authentication with failure lockout.              |
// | SCAN_AUTH_LOCKOUT_EN enables the timed lockout after MAX_ATTEMPTS fails. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module scan_unlock_auth #(
  parameter int SCAN_KEY_WIDTH  = 64,
  parameter int SCAN_KEY_NUMBER = 4,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_CYCLES  = 1024,
  localparam int IDX_W = (SCAN_KEY_NUMBER > 1) ? $clog2(SCAN_KEY_NUMBER) : 1,
  localparam int FC_W  = $clog2(MAX_ATTEMPTS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [SCAN_KEY_WIDTH-1:0] scan_key,
  input  logic                      scan_key_valid,
  input  logic                      relock,
  input  logic                      key_load_valid,
  input  logic [IDX_W-1:0]          key_load_index,
  input  logic [SCAN_KEY_WIDTH-1:0] key_load_data,
  input  logic                      key_lock,
  output logic                      scan_unlock,
  output logic                      auth_busy,
  output logic                      auth_done,
  output logic                      auth_pass,
  output logic                      locked_out,
  output logic [FC_W-1:0]           fail_count
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(SCAN_KEY_NUMBER - 1);
  localparam logic [FC_W-1:0]  C_MAX_FAIL = FC_W'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DECIDE  = 2'd2
`ifdef SCAN_AUTH_LOCKOUT_EN
    ,
    S_LOCKOUT = 2'd3
`endif
  } state_t;

  state_t                    r_state, w_state_nxt;
  logic [IDX_W-1:0]          r_idx, w_idx_nxt;
  logic [SCAN_KEY_WIDTH-1:0] r_cand, w_cand_nxt;
  logic                      r_match, w_match_nxt;
  logic                      r_unlock, w_unlock_nxt;
  logic                      r_pass, w_pass_nxt;
  logic [FC_W-1:0]           r_fail, w_fail_nxt;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_key_locked;
  logic                      w_wr_en;
  logic                      w_idx_ok;
  logic                      w_prov_frozen;
  logic                      w_hit;

  logic [SCAN_KEY_WIDTH-1:0] r_key   [SCAN_KEY_NUMBER];
  logic                      r_valid [SCAN_KEY_NUMBER];

`ifdef SCAN_AUTH_LOCKOUT_EN
  localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_LOCK_INIT = CNT_W'(LOCKOUT_CYCLES - 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_locked_out;
`endif

  // Provisioning freezes on the very cycle key_lock is first seen.
  assign w_prov_frozen = r_key_locked | key_lock;
  assign w_idx_ok      = ({{(32-IDX_W){1'b0}}, key_load_index} < 32'(SCAN_KEY_NUMBER));
  assign w_hit         = r_valid[r_idx] && (r_key[r_idx] == r_cand);

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cand_nxt   = r_cand;
    w_match_nxt  = r_match;
    w_unlock_nxt = r_unlock;
    w_pass_nxt   = r_pass;
    w_fail_nxt   = r_fail;
    w_wr_en      = 1'b0;
`ifdef SCAN_AUTH_LOCKOUT_EN
    w_cnt_nxt    = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (scan_key_valid) begin
          w_state_nxt = S_COMPARE;
          w_cand_nxt  = scan_key;
          w_match_nxt = 1'b0;
          w_idx_nxt   = '0;
        end else if (key_load_valid && !w_prov_frozen && w_idx_ok) begin
          w_wr_en = 1'b1;
        end
      end
      S_COMPARE: begin
        // Every entry is visited regardless of an early hit.
        w_match_nxt = r_match | w_hit;
        if (r_idx == C_LAST_IDX) begin
          w_state_nxt = S_DECIDE;
          w_pass_nxt  = w_match_nxt;
          if (w_match_nxt) begin
            w_unlock_nxt = 1'b1;
            w_fail_nxt   = '0;
          end else begin
`ifdef SCAN_AUTH_LOCKOUT_EN
            w_fail_nxt = r_fail + 1'b1;
`else
            if (r_fail != C_MAX_FAIL) begin
              w_fail_nxt = r_fail + 1'b1;
            end
`endif
          end
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      S_DECIDE: begin
`ifdef SCAN_AUTH_LOCKOUT_EN
        if (r_fail == C_MAX_FAIL) begin
          w_state_nxt = S_LOCKOUT;
          w_cnt_nxt   = C_LOCK_INIT;
        end else begin
          w_state_nxt = S_IDLE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
`ifdef SCAN_AUTH_LOCKOUT_EN
      S_LOCKOUT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
    // relock overrides a pass landing on the same edge.
    if (relock) begin
      w_unlock_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cand       <= '0;
      r_match      <= 1'b0;
      r_unlock     <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_key_locked <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cand       <= w_cand_nxt;
      r_match      <= w_match_nxt;
      r_unlock     <= w_unlock_nxt;
      r_pass       <= w_pass_nxt;
      r_fail       <= w_fail_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DECIDE);
      r_key_locked <= w_prov_frozen;
    end
  end

`ifdef SCAN_AUTH_LOCKOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_locked_out <= 1'b0;
    end else begin
      r_cnt        <= w_cnt_nxt;
      r_locked_out <= (w_state_nxt == S_LOCKOUT);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SCAN_KEY_NUMBER; i++) begin
        r_key[i]   <= '0;
        r_valid[i] <= 1'b0;
      end
    end else if (w_wr_en) begin
      r_key[key_load_index]   <= key_load_data;
      r_valid[key_load_index] <= 1'b1;
    end
  end

  assign scan_unlock = r_unlock;
  assign auth_busy   = r_busy;
  assign auth_done   = r_done;
  assign auth_pass   = r_pass;
  assign fail_count  = r_fail;
`ifdef SCAN_AUTH_LOCKOUT_EN
  assign locked_out  = r_locked_out;
`else
  assign locked_out  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scan_unlock_auth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_scan_unlock_auth                                                      |
// | Directed vector bench for scan_unlock_auth (N=4, W=64, 3 attempts, 16).  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_scan_unlock_auth;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int MA = 3;
  localparam int LC = 16;

  localparam logic [63:0] K_DEAD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] K_ZERO = 64'h0123_4567_89AB_CDEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  scan_key = '0;
  logic          scan_key_valid = 1'b0;
  logic          relock = 1'b0;
  logic          key_load_valid = 1'b0;
  logic [1:0]    key_load_index = '0;
  logic [W-1:0]  key_load_data = '0;
  logic          key_lock = 1'b0;
  logic          scan_unlock;
  logic          auth_busy;
  logic          auth_done;
  logic          auth_pass;
  logic          locked_out;
  logic [1:0]    fail_count;

  int n_checks = 0;
  int n_errors = 0;

  scan_unlock_auth #(
    .SCAN_KEY_WIDTH (W),
    .SCAN_KEY_NUMBER(N),
    .MAX_ATTEMPTS   (MA),
    .LOCKOUT_CYCLES (LC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .scan_key      (scan_key),
    .scan_key_valid(scan_key_valid),
    .relock        (relock),
    .key_load_valid(key_load_valid),
    .key_load_index(key_load_index),
    .key_load_data (key_load_data),
    .key_lock      (key_lock),
    .scan_unlock   (scan_unlock),
    .auth_busy     (auth_busy),
    .auth_done     (auth_done),
    .auth_pass     (auth_pass),
    .locked_out    (locked_out),
    .fail_count    (fail_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] key;
    logic        pass;
    logic        unlock;
    logic [1:0]  fails;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [63:0] d);
    key_load_valid = 1'b1;
    key_load_index = idx;
    key_load_data  = d;
    step();
    key_load_valid = 1'b0;
  endtask

  // Present a key in the current cycle; returns at the auth_done cycle.
  task automatic auth(input logic [63:0] k, input logic hold_relock, output int lat);
    scan_key       = k;
    scan_key_valid = 1'b1;
    relock         = hold_relock;
    lat            = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      step();
      scan_key_valid = 1'b0;
      if (auth_done) lat = c;
    end
    relock = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " scan_unlock"}, 64'(scan_unlock), 64'd0);
    check({tag, " auth_busy"},   64'(auth_busy),   64'd0);
    check({tag, " auth_done"},   64'(auth_done),   64'd0);
    check({tag, " auth_pass"},   64'(auth_pass),   64'd0);
    check({tag, " locked_out"},  64'(locked_out),  64'd0);
    check({tag, " fail_count"},  64'(fail_count),  64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lat;
    int lo_cycles;
    logic seen_done;

    vecs[0] = '{key: 64'h0,     pass: 1'b0, unlock: 1'b0, fails: 2'd1};
    vecs[1] = '{key: K_DEAD,    pass: 1'b1, unlock: 1'b1, fails: 2'd0};
    vecs[2] = '{key: K_ZERO,    pass: 1'b1, unlock: 1'b1, fails: 2'd0};
    vecs[3] = '{key: 64'h5,     pass: 1'b0, unlock: 1'b1, fails: 2'd1};
    vecs[4] = '{key: K_DEAD,    pass: 1'b1, unlock: 1'b1, fails: 2'd0};

    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    load(2'd2, K_DEAD);
    load(2'd0, K_ZERO);

    for (int i = 0; i < 5; i++) begin
      scan_key       = vecs[i].key;
      scan_key_valid = 1'b1;
      step();
      scan_key_valid = 1'b0;
      check($sformatf("vec%0d busy", i), 64'(auth_busy), 64'd1);
      step(); step(); step();
      check($sformatf("vec%0d early_done", i), 64'(auth_done), 64'd0);
      step();
      check($sformatf("vec%0d done", i),   64'(auth_done),   64'd1);
      check($sformatf("vec%0d pass", i),   64'(auth_pass),   64'(vecs[i].pass));
      check($sformatf("vec%0d unlock", i), 64'(scan_unlock), 64'(vecs[i].unlock));
      check($sformatf("vec%0d fails", i),  64'(fail_count),  64'(vecs[i].fails));
      step();
      check($sformatf("vec%0d done_pulse", i), 64'(auth_done), 64'd0);
    end

    relock = 1'b1;
    step();
    relock = 1'b0;
    check("relock unlock", 64'(scan_unlock), 64'd0);

`ifdef SCAN_AUTH_LOCKOUT_EN
    for (int i = 0; i < 3; i++) begin
      auth(64'hBAD0 + 64'(i), 1'b0, lat);
      check($sformatf("lo fail%0d latency", i), 64'(lat), 64'd5);
      check($sformatf("lo fail%0d count", i), 64'(fail_count), 64'(i + 1));
      step();
    end
    check("lo locked_out", 64'(locked_out), 64'd1);
    check("lo busy", 64'(auth_busy), 64'd1);
    check("lo count held", 64'(fail_count), 64'd3);
    scan_key       = K_DEAD;
    scan_key_valid = 1'b1;
    lo_cycles      = 0;
    seen_done      = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (!locked_out) break;
      lo_cycles++;
      step();
      scan_key_valid = 1'b0;
      if (auth_done) seen_done = 1'b1;
    end
    check("lo duration", 64'(lo_cycles), 64'(LC));
    check("lo key ignored", 64'(seen_done), 64'd0);
    check("lo busy after", 64'(auth_busy), 64'd0);
    check("lo count cleared", 64'(fail_count), 64'd0);
    auth(K_DEAD, 1'b0, lat);
    check("lo pass latency", 64'(lat), 64'd5);
    check("lo pass", 64'(auth_pass), 64'd1);
    step();
`else
    for (int i = 0; i < 5; i++) begin
      auth(64'hBAD0 + 64'(i), 1'b0, lat);
      check($sformatf("sat fail%0d latency", i), 64'(lat), 64'd5);
      check($sformatf("sat fail%0d count", i), 64'(fail_count), 64'((i < 2) ? i + 1 : 3));
      check($sformatf("sat fail%0d locked_out", i), 64'(locked_out), 64'd0);
      step();
    end
    auth(K_DEAD, 1'b0, lat);
    check("sat pass latency", 64'(lat), 64'd5);
    check("sat pass", 64'(auth_pass), 64'd1);
    check("sat count cleared", 64'(fail_count), 64'd0);
    step();
`endif

    key_lock = 1'b1;
    step();
    key_lock = 1'b0;
    load(2'd1, 64'h1111);
    auth(64'h1111, 1'b0, lat);
    check("keylock pass", 64'(auth_pass), 64'd0);
    check("keylock fails", 64'(fail_count), 64'd1);
    step();
    auth(K_DEAD, 1'b0, lat);
    check("keylock old key", 64'(auth_pass), 64'd1);
    check("keylock unlock", 64'(scan_unlock), 64'd1);
    step();

    scan_key       = K_DEAD;
    scan_key_valid = 1'b1;
    step();
    scan_key_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    step();
    rst_n = 1'b1;
    step();
    auth(K_DEAD, 1'b0, lat);
    check("postreset latency", 64'(lat), 64'd5);
    check("postreset pass", 64'(auth_pass), 64'd0);
    check("postreset fails", 64'(fail_count), 64'd1);
    step();

    load(2'd2, K_DEAD);
    auth(K_DEAD, 1'b1, lat);
    check("relock_pass pass", 64'(auth_pass), 64'd1);
    check("relock_pass unlock", 64'(scan_unlock), 64'd0);
    check("relock_pass fails", 64'(fail_count), 64'd0);
    step();

    key_load_valid = 1'b1;
    key_load_index = 2'd3;
    key_load_data  = 64'h9999;
    auth(64'h9999, 1'b0, lat);
    key_load_valid = 1'b0;
    check("collide pass", 64'(auth_pass), 64'd0);
    step();
    auth(64'h9999, 1'b0, lat);
    check("collide write dropped", 64'(auth_pass), 64'd0);
    check("collide fails", 64'(fail_count), 64'd2);
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
